// File: rtl/rr_req_arbiter_pkg.sv
// Shared types and defaults for the round-robin request arbiter.
// Widths here set the default N_REQ/IDX_W used by the pick and encode logic.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // OR-reduction encoder; the input is assumed one-hot or zero.
  function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between requesting agents (master) and the arbiter (slave).
interface rr_req_arbiter_if #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned IDX_W = 3
) ();

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout_err;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output timeout_err
  );

endinterface

// File: rtl/rr_req_arbiter_pick.sv
// Combinational round-robin pick: rotate req so ptr is bit 0, take the lowest set bit,
// rotate the result back. N_REQ must be a power of two so index sums wrap naturally.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = arb_pkg::N_REQ,
  parameter int unsigned IDX_W = arb_pkg::IDX_W
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_rot_pick;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rot[i] = i_req[IDX_W'(i) + i_ptr];
    end
  end

  assign w_rot_pick = w_rot & (~w_rot + N_REQ'(1));

  always_comb begin
    o_pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_pick[IDX_W'(i) + i_ptr] = w_rot_pick[i];
    end
  end

  assign o_idx = onehot2idx(o_pick);
  assign o_any = |i_req;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: IDLE/GRANT FSM, rotating priority pointer and registered grant.
// Define ARB_TIMEOUT_EN to force a release (with timeout_err) after TIMEOUT_CYC grant cycles.
module rr_req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ       = arb_pkg::N_REQ,
  parameter int unsigned IDX_W       = arb_pkg::IDX_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rr_req_arbiter_if.slave bus
);

  arb_state_e       r_state, w_state_d;
  logic [IDX_W-1:0] r_ptr, w_ptr_d;
  logic [N_REQ-1:0] r_gnt, w_gnt_d;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_d;

  logic [N_REQ-1:0] w_pick;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_any;
  logic             w_release;
  logic             w_force;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_any)
  );

  // done and a dropped owner request collapse into a single release.
  assign w_release = bus.done | ~bus.req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_tmo, w_tmo_d;

  // r_cnt is 0 during the first GRANT cycle, so the force fires on the TIMEOUT_CYC-th.
  assign w_force = (r_state == StGrant) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_cnt_d = (r_state == StGrant) ? r_cnt + CNT_W'(1) : '0;
  assign w_tmo_d = w_force & ~w_release;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_tmo <= w_tmo_d;
    end
  end

  assign bus.timeout_err = r_tmo;
`else
  assign w_force         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_gnt_d     = r_gnt;
    w_gnt_idx_d = r_gnt_idx;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_gnt_d     = w_pick;
          w_gnt_idx_d = w_pick_idx;
          w_state_d   = StGrant;
        end
      end
      StGrant: begin
        if (w_release || w_force) begin
          w_gnt_d     = '0;
          w_gnt_idx_d = '0;
          w_ptr_d     = r_gnt_idx + IDX_W'(1);
          w_state_d   = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
    end else begin
      r_state   <= w_state_d;
      r_ptr     <= w_ptr_d;
      r_gnt     <= w_gnt_d;
      r_gnt_idx <= w_gnt_idx_d;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt_vld = |r_gnt;

endmodule
